tx_ppdu_framer: RTL and testbench

//  Upstream of the transmitter: builds the serial DATA-field bitstream for one 802.11a PPDU.

---
 rtl/tx_ppdu_framer_pkg.sv | 28 ++
 rtl/tx_ppdu_framer_if.sv | 28 ++
 rtl/tx_ppdu_framer_crc32.sv | 26 ++
 rtl/tx_ppdu_framer.sv | 162 ++++++++++++++++
 tb/tb_tx_ppdu_framer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_ppdu_framer_pkg.sv
// Shared 802.11a DATA-field framing definitions: FSM encoding, field sizes, CRC-32 constants.
package ieee80211a_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_SERVICE = 3'd2,
    ST_DATA    = 3'd3,
    ST_FCS     = 3'd4,
    ST_TAIL    = 3'd5,
    ST_PAD     = 3'd6
  } state_t;

  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;
  localparam int FCS_BITS     = 32;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // The serial CRC shifts LSB first, so it works with the bit-reversed polynomial.
  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/tx_ppdu_framer_if.sv
// Request, byte-stream and transmitter-side signals of the PPDU framer.
interface tx_ppdu_framer_if;
  // Handshakes: a request is taken when Req is high in IDLE with a legal Len and is
  // acknowledged by a one-cycle ReqAck; a byte transfers on any rising edge where
  // ByteValid & ByteReady, and ByteReady never depends on ByteValid.
  logic        Req;
  logic [11:0] Len;
  logic        ReqAck;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        Start;
  logic        TransFrame;
  logic        FrameAct;
  logic [4:0]  num_pads;
  logic        Done;
  logic        Underrun;

  modport master (
    output Req, Len, ByteIn, ByteValid,
    input  ReqAck, ByteReady, Start, TransFrame, FrameAct, num_pads, Done, Underrun
  );

  modport slave (
    input  Req, Len, ByteIn, ByteValid,
    output ReqAck, ByteReady, Start, TransFrame, FrameAct, num_pads, Done, Underrun
  );
endinterface

// File: rtl/tx_ppdu_framer_crc32.sv
// Bit-serial reflected CRC-32; crc holds the raw register (invert it to get the FCS).
module tx_crc32
  import ieee80211a_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        serial_bit,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY_REFL = bit_reverse32(CRC32_POLY);

  logic feedback;
  assign feedback = crc[0] ^ serial_bit;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= CRC32_INIT;
    end else if (enable) begin
      crc <= {1'b0, crc[31:1]} ^ (feedback ? POLY_REFL : 32'd0);
    end
  end

endmodule

// File: rtl/tx_ppdu_framer.sv
// Serialises SERVICE + PSDU [+ FCS] + TAIL + PAD for one 802.11a PPDU, one bit per clock.
// Build option FRAMER_FCS_EN inserts a 32-bit CRC-32 FCS between the PSDU and the TAIL.
module tx_ppdu_framer
  import ieee80211a_pkg::*;
#(
  parameter int N_DBPS  = 24,
  parameter int MAX_LEN = 4095
) (
  input  logic              Clk,
  input  logic              Reset,
  tx_ppdu_framer_if.slave   bus,
  output state_t            dbg_state
);

  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);
  localparam logic [15:0] N_DBPS_W  = 16'(N_DBPS);
  localparam logic [4:0]  SVC_LAST  = 5'(SERVICE_BITS - 1);
  localparam logic [4:0]  TAIL_LAST = 5'(TAIL_BITS - 1);
  localparam logic [4:0]  FCS_LAST  = 5'(FCS_BITS - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [11:0] len_q;
  logic [11:0] out_cnt_q;
  logic [11:0] in_cnt_q;
  logic [7:0]  hold_q;
  logic        full_q;
  logic [7:0]  shift_q;
  logic [4:0]  pads_q;
  logic        done_q;

  logic        req_ok, bit_last, byte_last, load_now, underrun;
  logic        owed, fill_phase, byte_ready, byte_xfer, frame_end;
  logic [15:0] t_bits, t_rem;
  logic [4:0]  pads_calc;

  assign req_ok     = bus.Req && (bus.Len != 12'd0) && (bus.Len <= MAX_LEN_W);
  assign bit_last   = (cnt_q[2:0] == 3'd7);
  assign byte_last  = (out_cnt_q == len_q - 12'd1);
  // The holding register is drained into the shifter on the last SERVICE bit and on
  // the last bit of every PSDU byte that is not the final one.
  assign load_now   = ((state_q == ST_SERVICE) && (cnt_q == SVC_LAST)) ||
                      ((state_q == ST_DATA) && bit_last && !byte_last);
  assign underrun   = load_now && !full_q;
  assign owed       = (in_cnt_q != len_q);
  assign fill_phase = (state_q == ST_CALC) || (state_q == ST_SERVICE) || (state_q == ST_DATA);
  // Ready when empty and not at a load point, or full and being drained this cycle.
  assign byte_ready = fill_phase && owed && (full_q == load_now);
  assign byte_xfer  = byte_ready && bus.ByteValid;
  assign frame_end  = ((state_q == ST_TAIL) && (cnt_q == TAIL_LAST) && (pads_q == 5'd0)) ||
                      ((state_q == ST_PAD) && (cnt_q == pads_q - 5'd1));

`ifdef FRAMER_FCS_EN
  assign t_bits = 16'(SERVICE_BITS + TAIL_BITS + FCS_BITS) + {1'b0, len_q, 3'b000};
`else
  assign t_bits = 16'(SERVICE_BITS + TAIL_BITS) + {1'b0, len_q, 3'b000};
`endif
  assign t_rem     = t_bits % N_DBPS_W;
  assign pads_calc = (t_rem == 16'd0) ? 5'd0 : 5'(N_DBPS_W - t_rem);

`ifdef FRAMER_FCS_EN
  logic [31:0] crc;
  tx_crc32 u_crc (
    .clk        (Clk),
    .rst        (Reset),
    .clear      (state_q == ST_CALC),
    .enable     (state_q == ST_DATA),
    .serial_bit (shift_q[0]),
    .crc        (crc)
  );
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_ok) state_d = ST_CALC;
      ST_CALC:    state_d = ST_SERVICE;
      ST_SERVICE: if (cnt_q == SVC_LAST) state_d = underrun ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (bit_last) begin
          if (byte_last) begin
`ifdef FRAMER_FCS_EN
            state_d = ST_FCS;
`else
            state_d = ST_TAIL;
`endif
          end else if (underrun) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FCS:     if (cnt_q == FCS_LAST) state_d = ST_TAIL;
      ST_TAIL:    if (cnt_q == TAIL_LAST) state_d = frame_end ? ST_IDLE : ST_PAD;
      ST_PAD:     if (frame_end) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 5'd1;
    if ((state_q == ST_IDLE) || (state_d != state_q) || ((state_q == ST_DATA) && bit_last))
      cnt_d = 5'd0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q     <= 5'd0;
      len_q     <= 12'd0;
      out_cnt_q <= 12'd0;
      in_cnt_q  <= 12'd0;
      hold_q    <= 8'd0;
      full_q    <= 1'b0;
      shift_q   <= 8'd0;
      pads_q    <= 5'd0;
      done_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= frame_end;
      if ((state_q == ST_IDLE) && req_ok) len_q <= bus.Len;
      if (state_q == ST_CALC) pads_q <= pads_calc;
      if (state_q == ST_IDLE) begin
        out_cnt_q <= 12'd0;
        in_cnt_q  <= 12'd0;
        full_q    <= 1'b0;
      end else begin
        if (byte_xfer) begin
          hold_q   <= bus.ByteIn;
          full_q   <= 1'b1;
          in_cnt_q <= in_cnt_q + 12'd1;
        end else if (load_now) begin
          full_q <= 1'b0;
        end
        if (load_now)                shift_q <= hold_q;
        else if (state_q == ST_DATA) shift_q <= {1'b0, shift_q[7:1]};
        if ((state_q == ST_DATA) && bit_last) out_cnt_q <= out_cnt_q + 12'd1;
      end
    end
  end

  always_comb begin
    bus.ReqAck     = (state_q == ST_CALC);
    bus.ByteReady  = byte_ready;
    bus.Start      = (state_q == ST_SERVICE) && (cnt_q == 5'd0);
    bus.FrameAct   = (state_q == ST_SERVICE) || (state_q == ST_DATA) || (state_q == ST_FCS) ||
                     (state_q == ST_TAIL) || (state_q == ST_PAD);
    bus.TransFrame = 1'b0;
    if (state_q == ST_DATA) bus.TransFrame = shift_q[0];
`ifdef FRAMER_FCS_EN
    if (state_q == ST_FCS) bus.TransFrame = ~crc[cnt_q];
`endif
    bus.num_pads   = pads_q;
    bus.Done       = done_q;
    bus.Underrun   = underrun;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_tx_ppdu_framer.sv
// Directed bench for tx_ppdu_framer: table of frames plus underrun and mid-frame reset sequences.
module tb_tx_ppdu_framer;
  import ieee80211a_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  tx_ppdu_framer_if bus_if();

  tx_ppdu_framer #(.N_DBPS(24), .MAX_LEN(200)) dut (
    .Clk       (clk),
    .Reset     (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [95:0] data;
    int          exp_pads;
    int          exp_frame;
  } vec_t;

  vec_t vecs [5];

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_q [$];
  logic [0:0] got_q [$];

  int start_idx, done_idx, underrun_idx, pads_at_start;
  int stray_ack, idle_bad, extra_ready;
  bit drv_abort;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {bus_if.ReqAck, bus_if.ByteReady, bus_if.Start, bus_if.TransFrame, bus_if.FrameAct,
            bus_if.num_pads, bus_if.Done, bus_if.Underrun};
  endfunction

`ifdef FRAMER_FCS_EN
  function automatic logic [31:0] crc32_model(input int len, input logic [95:0] data);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 8 * len; i++) begin
      fb = c[0] ^ data[i];
      c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
    end
    return ~c;
  endfunction
`endif

  task automatic drive_bytes(input int len, input logic [95:0] data, input int give);
    int w;
    for (int k = 0; k < give && !drv_abort; k++) begin
      @(negedge clk);
      bus_if.ByteValid = 1'b1;
      bus_if.ByteIn    = data[8*k +: 8];
      w = 0;
      while (!bus_if.ByteReady && !drv_abort && w < 400) begin
        @(negedge clk);
        w++;
      end
    end
    @(negedge clk);
    if (give == len) begin
      // Keep offering a junk byte: the framer must not ask for more than Len.
      bus_if.ByteIn = 8'hFF;
      while (!drv_abort) begin
        if (bus_if.ByteReady) extra_ready++;
        @(negedge clk);
      end
    end
    bus_if.ByteValid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int len, input logic [95:0] data, input int give);
    int cyc;
    bit fin;
    got_q.delete();
    start_idx = -1; done_idx = -1; underrun_idx = -1; pads_at_start = 0;
    stray_ack = 0; idle_bad = 0; extra_ready = 0; drv_abort = 1'b0;
    fin = 1'b0;
    @(negedge clk);
    bus_if.Req = 1'b1;
    bus_if.Len = 12'(len);
    @(negedge clk);
    check({tag, "/req_ack"}, bus_if.ReqAck, 1);
    fork
      drive_bytes(len, data, give);
      begin
        cyc = 0;
        while (!fin && cyc < 400) begin
          @(negedge clk);
          if (bus_if.FrameAct) got_q.push_back(bus_if.TransFrame);
          else if (bus_if.TransFrame) idle_bad++;
          if (bus_if.Start) begin
            if (start_idx < 0) start_idx = cyc;
            pads_at_start = int'(bus_if.num_pads);
          end
          if (bus_if.ReqAck) stray_ack++;
          if (bus_if.Underrun && underrun_idx < 0) underrun_idx = cyc;
          if (bus_if.Done) begin
            done_idx = cyc;
            fin = 1'b1;
          end
          if (underrun_idx >= 0 && cyc > underrun_idx) fin = 1'b1;
          cyc++;
        end
        bus_if.Req = 1'b0;
        drv_abort  = 1'b1;
      end
    join
    bus_if.ByteValid = 1'b0;
    check({tag, "/timeout"}, fin, 1);
  endtask

  task automatic verify_frame(input string tag, input vec_t v);
    int nmis;
    int n;
`ifdef FRAMER_FCS_EN
    logic [31:0] fcs;
`endif
    exp_q.delete();
    repeat (16) exp_q.push_back(1'b0);
    for (int k = 0; k < v.len; k++)
      for (int b = 0; b < 8; b++) exp_q.push_back(v.data[8*k + b]);
`ifdef FRAMER_FCS_EN
    fcs = crc32_model(v.len, v.data);
    for (int b = 0; b < 32; b++) exp_q.push_back(fcs[b]);
`endif
    repeat (6) exp_q.push_back(1'b0);
    repeat (v.exp_pads) exp_q.push_back(1'b0);

    nmis = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) nmis++;

    check({tag, "/start_idx"}, start_idx, 0);
    check({tag, "/num_pads"}, pads_at_start, v.exp_pads);
    check({tag, "/frame_len"}, got_q.size(), v.exp_frame);
    check({tag, "/bit_errors"}, nmis, 0);
    check({tag, "/done_latency"}, done_idx, v.exp_frame);
    check({tag, "/no_underrun"}, underrun_idx < 0, 1);
    check({tag, "/no_req_reack"}, stray_ack, 0);
    check({tag, "/idle_bits_zero"}, idle_bad, 0);
    check({tag, "/no_extra_ready"}, extra_ready, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acks, dones;

`ifdef FRAMER_FCS_EN
    vecs[0] = '{1, 96'hA5, 10, 72};
    vecs[1] = '{3, 96'h3C815A, 18, 96};
    vecs[2] = '{2, 96'hF00F, 2, 72};
    vecs[3] = '{5, 96'h80_08_04_02_01, 2, 96};
    vecs[4] = '{9, 96'h39_38_37_36_35_34_33_32_31, 18, 144};
`else
    vecs[0] = '{1, 96'hA5, 18, 48};
    vecs[1] = '{3, 96'h3C815A, 2, 48};
    vecs[2] = '{2, 96'hF00F, 10, 48};
    vecs[3] = '{5, 96'h80_08_04_02_01, 10, 72};
    vecs[4] = '{9, 96'h39_38_37_36_35_34_33_32_31, 2, 96};
`endif

    rst = 1'b1;
    bus_if.Req = 1'b0;
    bus_if.Len = 12'd0;
    bus_if.ByteIn = 8'd0;
    bus_if.ByteValid = 1'b0;
    drv_abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/outputs", outs(), 12'd0);
    check("reset/state", dbg_state, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset/outputs", outs(), 12'd0);

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].data, vecs[i].len);
      verify_frame($sformatf("vec%0d", i), vecs[i]);
    end

`ifdef FRAMER_FCS_EN
    begin
      logic [31:0] fcs_word;
      fcs_word = 32'd0;
      for (int b = 0; b < 32; b++)
        if (88 + b < got_q.size()) fcs_word[b] = got_q[88 + b];
      check("fcs/known_answer", fcs_word, 32'hCBF43926);
    end
`endif

    // Len=4 with only one byte supplied: the second byte is missing at frame bit 24.
    run_frame("underrun", 4, 96'h44_33_22_11, 1);
    check("underrun/cycle", underrun_idx, 23);
    check("underrun/frame_bits", got_q.size(), 24);
    check("underrun/no_done", done_idx < 0, 1);
    check("underrun/state", dbg_state, ST_IDLE);
    check("underrun/ready_low", bus_if.ByteReady, 0);

    run_frame("after_underrun", vecs[1].len, vecs[1].data, vecs[1].len);
    verify_frame("after_underrun", vecs[1]);

    // Reset in the middle of the PSDU, then illegal lengths must not be acknowledged.
    @(negedge clk);
    bus_if.Req = 1'b1;
    bus_if.Len = 12'd4;
    @(negedge clk);
    check("mid_reset/req_ack", bus_if.ReqAck, 1);
    bus_if.Req = 1'b0;
    extra_ready = 0;
    drv_abort = 1'b0;
    fork
      drive_bytes(4, 96'h44_33_22_11, 4);
      begin
        repeat (28) @(negedge clk);
        check("mid_reset/in_data", dbg_state, ST_DATA);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset/outputs", outs(), 12'd0);
        check("mid_reset/state", dbg_state, ST_IDLE);
        drv_abort = 1'b1;
        rst = 1'b0;
      end
    join
    bus_if.ByteValid = 1'b0;

    acks = 0;
    dones = 0;
    bus_if.Req = 1'b1;
    bus_if.Len = 12'd0;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.ReqAck) acks++;
      if (bus_if.Done) dones++;
    end
    bus_if.Len = 12'd300;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.ReqAck) acks++;
      if (bus_if.Done) dones++;
    end
    bus_if.Req = 1'b0;
    check("illegal_len/no_ack", acks, 0);
    check("mid_reset/no_done", dones, 0);

    run_frame("after_reset", vecs[0].len, vecs[0].data, vecs[0].len);
    verify_frame("after_reset", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
